// File: rtl/recip_nr_ctrl_pkg.sv
// Shared constants for the Newton-Raphson reciprocal controller: state encoding,
// IEEE-754 double constants and the seed exponent offset.
package recip_nr_ctrl_pkg;

   localparam int unsigned DP_LEN      = 64;
   localparam int unsigned EXP_BIAS    = 1023;
   // Seed exponent 2045 - e puts |b*X0| in [0.5, 1)
   localparam int unsigned SEED_OFFSET = 2 * EXP_BIAS - 1;

   localparam logic [DP_LEN-1:0] QNAN    = 64'h7FF8_0000_0000_0000;
   localparam logic [DP_LEN-1:0] POS_INF = 64'h7FF0_0000_0000_0000;
   localparam logic [DP_LEN-1:0] TWO     = 64'h4000_0000_0000_0000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/recip_nr_ctrl_seed.sv
// Combinational divisor classifier: builds the X0 seed, the special-operand
// result and the divide-by-zero flag.
module recip_seed
   import recip_nr_ctrl_pkg::*;
#(
   parameter int unsigned precision_LEN = 64,
   parameter int unsigned exp_LEN       = 11,
   parameter int unsigned frac_LEN      = 52
) (
   input  logic [precision_LEN-1:0] b,
   output logic                     special_c,
   output logic                     dz_c,
   output logic [precision_LEN-1:0] x0_c,
   output logic [precision_LEN-1:0] result_c
);

   localparam logic [exp_LEN-1:0] EXP_MAX  = '1;
   localparam logic [exp_LEN-1:0] EXP_SEED = exp_LEN'(SEED_OFFSET);

   logic                sgn;
   logic [exp_LEN-1:0]  e;
   logic [frac_LEN-1:0] frac;

   assign sgn  = b[precision_LEN-1];
   assign e    = b[precision_LEN-2 -: exp_LEN];
   assign frac = b[frac_LEN-1:0];

   // Zero/subnormal (flushed), inf/NaN and huge divisors bypass the datapath
   always_comb begin
      special_c = 1'b0;
      dz_c      = 1'b0;
      x0_c      = {sgn, EXP_SEED - e, {frac_LEN{1'b0}}};
      result_c  = {sgn, {(precision_LEN-1){1'b0}}};
      if (e == '0) begin
         special_c = 1'b1;
         dz_c      = 1'b1;
         result_c  = {sgn, POS_INF[precision_LEN-2:0]};
      end else if (e == EXP_MAX) begin
         special_c = 1'b1;
         if (frac != '0) result_c = precision_LEN'(QNAN);
      end else if (e >= EXP_SEED) begin
         special_c = 1'b1;
      end
   end

endmodule

// File: rtl/recip_nr_ctrl.sv
// Sequencing FSM for the Newton-Raphson reciprocal step datapath.
// Optional RECIP_EARLY_EXIT_EN: finish as soon as an iteration leaves X unchanged.
module recip_nr_ctrl
   import recip_nr_ctrl_pkg::*;
#(
   parameter int unsigned precision_LEN = 64,
   parameter int unsigned exp_LEN       = 11,
   parameter int unsigned frac_LEN      = 52,
   parameter int unsigned ITER          = 6,
   parameter int unsigned STEP_LAT      = 6
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [precision_LEN-1:0] in_b,
   output logic                     step_en,
   output logic [precision_LEN-1:0] step_b,
   output logic [precision_LEN-1:0] step_x,
   input  logic [precision_LEN-1:0] step_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [precision_LEN-1:0] out_recip,
   output logic                     out_dz,
   output logic                     busy
);

   localparam int unsigned ITER_W = $clog2(ITER + 1);
   localparam int unsigned LAT_W  = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;

   logic [1:0]               state_q, state_d;
   logic [ITER_W-1:0]        iter_q, iter_d;
   logic [LAT_W-1:0]         lat_q, lat_d;
   logic                     step_en_d, out_valid_d, out_dz_d;
   logic [precision_LEN-1:0] step_b_d, step_x_d, out_recip_d;
   logic                     special_c, dz_c, converged_c, last_c;
   logic [precision_LEN-1:0] x0_c, special_result_c;

   recip_seed #(
      .precision_LEN (precision_LEN),
      .exp_LEN       (exp_LEN),
      .frac_LEN      (frac_LEN)
   ) u_seed (
      .b         (in_b),
      .special_c (special_c),
      .dz_c      (dz_c),
      .x0_c      (x0_c),
      .result_c  (special_result_c)
   );

   // step_x always holds the current Xn, so it doubles as the convergence reference
`ifdef RECIP_EARLY_EXIT_EN
   assign converged_c = (step_result == step_x);
`else
   assign converged_c = 1'b0;
`endif
   assign last_c = ((iter_q + ITER_W'(1)) == ITER_W'(ITER)) || converged_c;

   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      lat_d       = lat_q;
      step_en_d   = 1'b0;
      step_b_d    = step_b;
      step_x_d    = step_x;
      out_valid_d = out_valid;
      out_recip_d = out_recip;
      out_dz_d    = out_dz;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (special_c) begin
                  out_valid_d = 1'b1;
                  out_recip_d = special_result_c;
                  out_dz_d    = dz_c;
                  state_d     = ST_DONE;
               end else begin
                  iter_d    = '0;
                  step_en_d = 1'b1;
                  step_b_d  = in_b;
                  step_x_d  = x0_c;
                  state_d   = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            lat_d   = LAT_W'(STEP_LAT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q != '0) begin
               lat_d = lat_q - LAT_W'(1);
            end else begin
               iter_d = iter_q + ITER_W'(1);
               if (last_c) begin
                  out_valid_d = 1'b1;
                  out_recip_d = step_result;
                  out_dz_d    = 1'b0;
                  state_d     = ST_DONE;
               end else begin
                  step_en_d = 1'b1;
                  step_x_d  = step_result;
                  state_d   = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= ST_IDLE;
         iter_q    <= '0;
         lat_q     <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         step_en   <= 1'b0;
         step_b    <= '0;
         step_x    <= '0;
         out_valid <= 1'b0;
         out_recip <= '0;
         out_dz    <= 1'b0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         lat_q     <= lat_d;
         in_ready  <= (state_d == ST_IDLE);
         busy      <= (state_d != ST_IDLE);
         step_en   <= step_en_d;
         step_b    <= step_b_d;
         step_x    <= step_x_d;
         out_valid <= out_valid_d;
         out_recip <= out_recip_d;
         out_dz    <= out_dz_d;
      end
   end

endmodule

// File: doc/recip_nr_ctrl.md
# recip_nr_ctrl

- Sequencing controller for the Newton–Raphson reciprocal step datapath (Xn+1 = Xn·(2 − b·Xn), fixed-latency, non-stalling).
- Accepts one double-precision divisor over a valid/ready handshake, builds the initial estimate X0 and issues ITER back-to-back step operations.
- Resolves special operands without touching the datapath and returns 1/b over a second valid/ready handshake.
- Sits between the divide front end and the reciprocal step instance; one operation in flight at a time.

## Interface
- precision_LEN, 64, operand width
- exp_LEN, 11, exponent width
- frac_LEN, 52, fraction width
- ITER, 6, Newton iterations per operation (≥1)
- STEP_LAT, 6, cycles from step_en to valid step_result (≥1); must match the step instance
- clk  in  1  single clock, rising edge
- srst  in  1  synchronous, active-high reset
- in_valid  in  1  divisor offered
- in_ready  out  1  controller idle and able to accept
- in_b  in  precision_LEN  divisor b (IEEE-754)
- step_en  out  1  one-cycle issue strobe to the datapath
- step_b  out  precision_LEN  b operand to the datapath
- step_x  out  precision_LEN  Xn operand to the datapath
- step_result  in  precision_LEN  Xn+1 from the datapath, sampled STEP_LAT cycles after step_en
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_recip  out  precision_LEN  1/b
- out_dz  out  1  divide-by-zero flag, qualified by out_valid
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, register b.
  - Special operand → out_recip loaded, → DONE.
  - Otherwise X0 = {sign(b), 2045 − e, 52'b0}, iter_cnt=0, → ISSUE.
- Special operands (e = exponent field):
  - e=0 (zero/subnormal, flushed): ±inf with sign of b, out_dz=1.
  - e=2047 with frac=0: ±0.
  - e=2047 with frac≠0: 0x7FF8000000000000.
  - e≥2045: ±0.
- ISSUE: step_en=1 for one cycle, step_b=b, step_x=X; lat_cnt=STEP_LAT−1; → WAIT.
- WAIT: lat_cnt decrements. At lat_cnt=0: capture X←step_result, iter_cnt+1.
  - If iter_cnt reaches ITER → DONE; else → ISSUE.
- DONE: out_valid=1, out_recip=X. On out_ready → IDLE.
  - The next input is accepted no earlier than the following cycle.
- step_b/step_x hold their value outside ISSUE; the datapath ignores them without step_en.
- Seed guarantees |b·X0| ∈ [0.5,1). ITER=6 reaches full double precision (final error ≤1 ulp).

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - step_en=0
  - step_b=0, step_x=0
  - out_valid=0, out_recip=0, out_dz=0
  - busy=0
- Accept at cycle 0 → first step_en at cycle 1. Iteration k issues at cycle 1+k·(STEP_LAT+1).
- out_valid at cycle 1+ITER·(STEP_LAT+1). Default ITER=6, STEP_LAT=6: cycle 43.
- Special operands: out_valid at cycle 1.
- out_valid and out_recip are held stable until out_ready. No result is dropped.
- srst mid-operation: IDLE next cycle. Any in-flight step_result is ignored because the capture only happens in WAIT. No out_valid is produced for the aborted operation.
- in_valid while busy: not accepted (in_ready=0); the input must be held by the source.

## Configuration
- RECIP_EARLY_EXIT_EN defined:
  - In WAIT capture, if step_result == X (bit-exact), → DONE immediately regardless of iter_cnt.
  - Latency then becomes variable, ≤ the fixed value.
- RECIP_EARLY_EXIT_EN undefined: exactly ITER iterations always; latency fixed.

## Structure
- Shared package holds:
  - state enum
  - DP exponent bias (1023) and seed offset (2045)
  - IEEE constants: qNaN 0x7FF8000000000000, +inf 0x7FF0000000000000, 2.0 0x4000000000000000
- One natural sub-module: recip_seed.
  - Combinational; classifies b and produces X0, the special-case result and the dz flag.
- FSM, counters and handshake stay in recip_nr_ctrl.
- The step datapath is instantiated by the parent, not inside this block.

## Test plan
- b=0x4000000000000000 (2.0) → out_recip=0x3FE0000000000000 at cycle 43; exactly 6 step_en pulses, spaced 7 cycles apart.
- b=0x4008000000000000 (3.0) → out_recip within 1 ulp of 0x3FD5555555555555.
- b=0xC010000000000000 (−4.0) → out_recip=0xBFD0000000000000.
- Special operands:
  - b=0x0000000000000000 → 0x7FF0000000000000, out_dz=1, out_valid at cycle 1, no step_en.
  - b=0x7FF0000000000001 → 0x7FF8000000000000.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles → out_valid/out_recip stable, in_ready=0.
  - Assert srst at cycle 20 of an operation → IDLE next cycle, no out_valid.
  - A following b=2.0 completes normally.
- RECIP_EARLY_EXIT_EN, ITER=10, b=2.0 → out_valid before cycle 71, out_recip=0x3FE0000000000000.
